// File: rtl/hilo_mult_sequencer.sv
// HI/LO owner and multi-cycle multiply sequencer for the EX stage.
// Optional HILO_FAST_MULT_EN: single-cycle product instead of shift-add.
module hilo_mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [5:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [5:0] OP_MADD  = 6'd2;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_MSUB  = 6'd8;
    localparam logic [5:0] OP_MFHI  = 6'd15;
    localparam logic [5:0] OP_MTHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd17;
    localparam logic [5:0] OP_MTLO  = 6'd18;
    localparam logic [5:0] OP_MULT  = 6'd19;
    localparam logic [5:0] OP_MULTU = 6'd20;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIX,
        WB
    } state_t;

    state_t               state;
    logic [5:0]           op_q;
    logic                 sign_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     result_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 accept;
    logic                 rd_hi;
    logic                 rd_lo;
    logic                 is_unsigned;
    logic [WIDTH-1:0]     ua;
    logic [WIDTH-1:0]     ub;
    logic                 neg_in;
    logic [2*WIDTH-1:0]   hilo;
    logic [2*WIDTH-1:0]   madd_sum;
    logic [2*WIDTH-1:0]   msub_dif;

    // Operand conditioning: magnitudes for signed ops, raw for multu
    assign accept      = Start & ~Flush & (state == IDLE);
    assign is_unsigned = (ALUOp == OP_MULTU);
    assign ua          = (!is_unsigned && A[WIDTH-1]) ? -A : A;
    assign ub          = (!is_unsigned && B[WIDTH-1]) ? -B : B;
    assign neg_in      = !is_unsigned && (A[WIDTH-1] ^ B[WIDTH-1]);

    assign hilo     = {hi_q, lo_q};
    assign madd_sum = hilo + acc_q;
    assign msub_dif = hilo - acc_q;

    // Reads of HI/LO bypass to Result in the issue cycle
    assign rd_hi  = Rst & accept & (ALUOp == OP_MFHI);
    assign rd_lo  = Rst & accept & (ALUOp == OP_MFLO);
    assign Result = rd_hi ? hi_q : (rd_lo ? lo_q : result_q);

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Stall = Start & busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

`ifdef HILO_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, ua} * {{WIDTH{1'b0}}, ub};
`else
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign mul_step = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};
`endif

    // Sequencer FSM owning HI/LO, Result and the handshake flags
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            op_q     <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifndef HILO_FAST_MULT_EN
            cnt_q    <= '0;
            mcand_q  <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        case (ALUOp)
                            OP_MTHI: hi_q     <= A;
                            OP_MTLO: lo_q     <= A;
                            OP_MFHI: result_q <= hi_q;
                            OP_MFLO: result_q <= lo_q;
                            OP_MADD, OP_MUL, OP_MSUB,
                            OP_MULT, OP_MULTU: begin
                                op_q   <= ALUOp;
                                sign_q <= neg_in;
                                busy_q <= 1'b1;
`ifdef HILO_FAST_MULT_EN
                                acc_q  <= fast_prod;
                                state  <= FIX;
`else
                                acc_q   <= {{WIDTH{1'b0}}, ub};
                                mcand_q <= ua;
                                cnt_q   <= CW'(WIDTH - 1);
                                state   <= MUL;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
`ifdef HILO_FAST_MULT_EN
                    state  <= IDLE;
                    busy_q <= 1'b0;
`else
                    if (Flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc_q <= mul_step;
                        if (cnt_q == '0)
                            state <= FIX;
                        else
                            cnt_q <= cnt_q - CW'(1);
                    end
`endif
                end
                FIX: begin
                    if (Flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (sign_q)
                            acc_q <= -acc_q;
                        state  <= WB;
                        done_q <= 1'b1;
                    end
                end
                WB: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (!Flush) begin
                        case (op_q)
                            OP_MULT, OP_MULTU: {hi_q, lo_q} <= acc_q;
                            OP_MADD:           {hi_q, lo_q} <= madd_sum;
                            OP_MSUB:           {hi_q, lo_q} <= msub_dif;
                            OP_MUL:            result_q <= acc_q[WIDTH-1:0];
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for hilo_mult_sequencer.
// Expected values are hand-computed constants.
module tb_hilo_mult_sequencer;

    localparam logic [5:0] OP_MADD  = 6'd2;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_MSUB  = 6'd8;
    localparam logic [5:0] OP_MFHI  = 6'd15;
    localparam logic [5:0] OP_MTHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd17;
    localparam logic [5:0] OP_MTLO  = 6'd18;
    localparam logic [5:0] OP_MULT  = 6'd19;
    localparam logic [5:0] OP_MULTU = 6'd20;

`ifdef HILO_FAST_MULT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 34;
`endif
    localparam int S0 = (LAT > 5) ? 5 : 1;
    localparam int F0 = (LAT > 10) ? 10 : 1;
    localparam int R0 = (LAT > 20) ? 20 : 1;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [5:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    hilo_mult_sequencer #(.WIDTH(32)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .ALUOp  (ALUOp),
        .A      (A),
        .B      (B),
        .Flush  (Flush),
        .Busy   (Busy),
        .Stall  (Stall),
        .Done   (Done),
        .Result (Result),
        .HI     (HI),
        .LO     (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic op1(input logic [5:0] op, input logic [31:0] a);
        Start = 1'b1;
        ALUOp = op;
        A     = a;
        step();
        Start = 1'b0;
    endtask

    task automatic run(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
        int lat;
        Start = 1'b1;
        ALUOp = op;
        A     = a;
        B     = b;
        step();
        Start = 1'b0;
        chk({tag, "_busy_c1"}, Busy, 1);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (Done) begin
                lat = c;
                break;
            end
            step();
        end
        chk({tag, "_done_cycle"}, lat, LAT);
        step();
        chk({tag, "_idle_after"}, {Busy, Done}, 2'b00);
    endtask

    initial begin
        int bad;
        int seen;
        checks = 0;
        errors = 0;
        Rst    = 1'b0;
        Start  = 1'b0;
        Flush  = 1'b0;
        ALUOp  = '0;
        A      = '0;
        B      = '0;
        #12;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_flags", {Busy, Done, Stall}, 3'b000);
        chk("rst_result", Result, 0);
        step();
        Rst = 1'b1;
        step();

        run(OP_MULT, 32'hFFFF_FFFF, 32'h2, "mult");
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFE);

        run(OP_MULTU, 32'hFFFF_FFFF, 32'h2, "multu");
        chk("multu_hi", HI, 32'h1);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        op1(OP_MTLO, 32'd5);
        chk("mtlo_lo", LO, 32'd5);
        chk("mtlo_busy", Busy, 0);
        op1(OP_MTHI, 32'd0);
        chk("mthi_hi", HI, 32'd0);
        run(OP_MADD, 32'd3, 32'd4, "madd");
        chk("madd_hi", HI, 32'h0);
        chk("madd_lo", LO, 32'h11);
        run(OP_MSUB, 32'h11, 32'd1, "msub");
        chk("msub_hi", HI, 32'h0);
        chk("msub_lo", LO, 32'h0);

        op1(OP_MTHI, 32'h1234);
        op1(OP_MTLO, 32'h5678);
        run(OP_MUL, 32'hFFFF_FFFD, 32'd7, "mul");
        chk("mul_result", Result, 32'hFFFF_FFEB);
        chk("mul_hi", HI, 32'h1234);
        chk("mul_lo", LO, 32'h5678);

        Start = 1'b1;
        ALUOp = OP_MFHI;
        #1;
        chk("mfhi_comb", Result, 32'h1234);
        step();
        Start = 1'b0;
        #1;
        chk("mfhi_hold", Result, 32'h1234);
        Start = 1'b1;
        ALUOp = OP_MFLO;
        #1;
        chk("mflo_comb", Result, 32'h5678);
        step();
        Start = 1'b0;

        run(OP_MULT, 32'h8000_0000, 32'h8000_0000, "minmin");
        chk("minmin_hi", HI, 32'h4000_0000);
        chk("minmin_lo", LO, 32'h0);
        run(OP_MULT, 32'h8000_0000, 32'h1, "minone");
        chk("minone_hi", HI, 32'hFFFF_FFFF);
        chk("minone_lo", LO, 32'h8000_0000);

        Start = 1'b1;
        ALUOp = OP_MULT;
        A     = 32'd3;
        B     = 32'd5;
        step();
        Start = 1'b0;
        for (int c = 1; c < S0; c++) step();
        Start = 1'b1;
        ALUOp = OP_MFLO;
        #1;
        bad = 0;
        for (int c = S0; c <= LAT; c++) begin
            if (!Stall) bad++;
            step();
        end
        chk("stall_cycles_bad", bad, 0);
        chk("stall_released", Stall, 0);
        chk("mflo_after_stall", Result, 32'd15);
        step();
        Start = 1'b0;
        chk("mflo_hold", Result, 32'd15);
        chk("stall_hi", HI, 32'd0);

        Start = 1'b1;
        ALUOp = OP_MADD;
        A     = 32'd2;
        B     = 32'd2;
        step();
        Start = 1'b0;
        for (int c = 1; c < F0; c++) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush_busy", Busy, 0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (Done) seen++;
            step();
        end
        chk("flush_no_done", seen, 0);
        chk("flush_hi", HI, 32'd0);
        chk("flush_lo", LO, 32'd15);

        Start = 1'b1;
        Flush = 1'b1;
        ALUOp = OP_MTHI;
        A     = 32'hDEAD;
        step();
        Start = 1'b0;
        Flush = 1'b0;
        chk("flush_mthi", HI, 32'd0);

        Start = 1'b1;
        ALUOp = OP_MULT;
        A     = 32'd7;
        B     = 32'd9;
        step();
        Start = 1'b0;
        for (int c = 1; c < R0; c++) step();
        Rst = 1'b0;
        #1;
        chk("arst_hi", HI, 0);
        chk("arst_lo", LO, 0);
        chk("arst_flags", {Busy, Done}, 2'b00);
        chk("arst_result", Result, 0);
        step();
        Rst = 1'b1;
        step();
        run(OP_MULTU, 32'd6, 32'd7, "recover");
        chk("recover_lo", LO, 32'd42);
        chk("recover_hi", HI, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
